// File: rtl/mac_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mac_ctrl_pkg : FSM states and tile instruction encodings shared by   |
// |                the row and array controllers.  Revision 1.0          |
// +----------------------------------------------------------------------+
package mac_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic [1:0] INST_NOP  = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

endpackage : mac_ctrl_pkg
`default_nettype wire

// File: rtl/mac_ctrl_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mac_ctrl_cnt : loadable up-counter with enable and terminal-count    |
// |                flag (count == term).  Revision 1.0                   |
// +----------------------------------------------------------------------+
module mac_ctrl_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic [WIDTH-1:0] term,
  output logic             tc
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Load has priority so a job start always begins from a clean count.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == term);

endmodule : mac_ctrl_cnt
`default_nettype wire

// File: rtl/mac_row_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mac_row_ctrl : sequences one row of mac_tiles - kernel load, then    |
// |                activation execute, then drain, then done pulse.      |
// |                Revision 1.0                                          |
// +----------------------------------------------------------------------+
module mac_row_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int bw     = 4,
  parameter int col    = 8,
  parameter int len_bw = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [len_bw-1:0] num_act,
  input  logic              w_valid,
  input  logic [bw-1:0]     w_data,
  output logic              w_ready,
  input  logic              a_valid,
  input  logic [bw-1:0]     a_data,
  output logic              a_ready,
  output logic [bw-1:0]     in_w,
  output logic [1:0]        inst_w,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(col + 1);
  localparam logic [CW-1:0] COL_TERM = CW'(col - 1);

  state_e            state_q, state_d;
  logic [len_bw-1:0] num_act_q, num_act_d;
  logic [bw-1:0]     in_w_q, in_w_d;
  logic [1:0]        inst_w_q, inst_w_d;
  logic              done_q, done_d;

  logic w_xfer;
  logic a_xfer;
  logic start_acc;
  logic load_tc;
  logic exec_tc;
  logic drain_tc;

  // Ready is a pure state decode so upstream buffers never see a
  // combinational path from their own valid back to ready.
  assign w_ready   = (state_q == ST_LOAD);
  assign a_ready   = (state_q == ST_EXEC);
  assign busy      = (state_q != ST_IDLE);
  assign w_xfer    = w_valid & w_ready;
  assign a_xfer    = a_valid & a_ready;
  assign start_acc = (state_q == ST_IDLE) & start;

  mac_ctrl_cnt #(.WIDTH(CW)) u_load_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (start_acc),
    .load_val ('0),
    .en       (w_xfer),
    .term     (COL_TERM),
    .tc       (load_tc)
  );

  // Terminal value is num_act-1; unused when num_act is 0 since EXEC is skipped.
  mac_ctrl_cnt #(.WIDTH(len_bw)) u_exec_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (start_acc),
    .load_val ('0),
    .en       (a_xfer),
    .term     (num_act_q - len_bw'(1)),
    .tc       (exec_tc)
  );

  mac_ctrl_cnt #(.WIDTH(CW)) u_drain_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (start_acc),
    .load_val ('0),
    .en       (state_q == ST_DRAIN),
    .term     (COL_TERM),
    .tc       (drain_tc)
  );

  always_comb begin
    state_d   = state_q;
    num_act_d = num_act_q;
    in_w_d    = '0;
    inst_w_d  = INST_NOP;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_act_d = num_act;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_xfer) begin
          in_w_d   = w_data;
          inst_w_d = INST_LOAD;
          if (load_tc) begin
            state_d = (num_act_q == '0) ? ST_DRAIN : ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (a_xfer) begin
          in_w_d   = a_data;
          inst_w_d = INST_EXEC;
          if (exec_tc) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_tc) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      num_act_q <= '0;
      in_w_q    <= '0;
      inst_w_q  <= INST_NOP;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_act_q <= num_act_d;
      in_w_q    <= in_w_d;
      inst_w_q  <= inst_w_d;
      done_q    <= done_d;
    end
  end

  assign in_w   = in_w_q;
  assign inst_w = inst_w_q;
  assign done   = done_q;

endmodule : mac_row_ctrl
`default_nettype wire

// File: tb/tb_mac_row_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mac_row_ctrl : directed jobs with a transfer/done scoreboard.     |
// |                   Revision 1.0                                       |
// +----------------------------------------------------------------------+
module tb_mac_row_ctrl;

  localparam int BW  = 4;
  localparam int COL = 8;
  localparam int LBW = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [LBW-1:0] num_act;
  logic           w_valid;
  logic [BW-1:0]  w_data;
  logic           w_ready;
  logic           a_valid;
  logic [BW-1:0]  a_data;
  logic           a_ready;
  logic [BW-1:0]  in_w;
  logic [1:0]     inst_w;
  logic           busy;
  logic           done;

  mac_row_ctrl #(.bw(BW), .col(COL), .len_bw(LBW)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .num_act (num_act),
    .w_valid (w_valid),
    .w_data  (w_data),
    .w_ready (w_ready),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_ready (a_ready),
    .in_w    (in_w),
    .inst_w  (inst_w),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  logic [BW-1:0] wts  [COL] = '{4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
  logic [BW-1:0] acts [6]   = '{4'h1, 4'hC, 4'hD, 4'h9, 4'hF, 4'h1};

  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [5:0]  sq[$];
  int          dq[$];
  bit          prev_done = 1'b0;
  bit          expect_restart = 1'b0;
  bit          no_a_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expected beat for every non-NOP instruction and an
  // expected edge number for every done pulse.
  always @(negedge clk) begin
    if (!reset) begin
      chk("reset_outputs", {22'd0, in_w, inst_w, busy, done, w_ready, a_ready}, 32'd0);
      prev_done = 1'b0;
    end else begin
      chk("ready_exclusive", {31'd0, w_ready & a_ready}, 32'd0);
      if (no_a_ready) chk("a_ready_zero_act", {31'd0, a_ready}, 32'd0);
      if (inst_w != 2'b00) begin
        if (sq.size() == 0) begin
          chk("unexpected_xfer", {26'd0, inst_w, in_w}, 32'd0);
        end else begin
          chk("xfer", {26'd0, inst_w, in_w}, {26'd0, sq.pop_front()});
        end
      end else begin
        chk("bubble_in_w", {28'd0, in_w}, 32'd0);
      end
      if (!busy) chk("idle_outputs", {24'd0, in_w, inst_w, w_ready, a_ready}, 32'd0);
      if (done) begin
        chk("done_busy", {31'd0, busy}, 32'd0);
        if (dq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else chk("done_cycle", cyc, dq.pop_front());
      end
      if (prev_done && expect_restart) chk("restart_load", {30'd0, busy, w_ready}, 32'd3);
      prev_done = done;
    end
  end

  // Called at a negedge: start is sampled by the next edge k = cyc+1.
  task automatic begin_job(input int na, input int stalls);
    start   = 1'b1;
    num_act = LBW'(na);
    dq.push_back(cyc + 1 + 2 * COL + na + stalls);
  endtask

  task automatic feed(input int na, input int ws_at, input int ws_len,
                      input int as_at, input int as_len,
                      input bit pulse, input bit abort);
    int ws = 0;
    int as = 0;
    int wr = ws_len;
    int ar = as_len;
    int guard = 0;
    while ((ws < COL || as < na) && guard < 300) begin
      @(negedge clk);
      guard++;
      start   = 1'b0;
      w_valid = 1'b0;
      a_valid = 1'b0;
      w_data  = 4'hA;
      a_data  = 4'h5;
      if (ws < COL) begin
        a_valid = 1'($urandom);
        if (ws == ws_at && wr > 0) begin
          wr--;
        end else begin
          w_valid = 1'b1;
          w_data  = wts[ws];
          if (w_ready) begin
            sq.push_back({2'b01, wts[ws]});
            ws++;
          end
        end
      end else begin
        w_valid = 1'($urandom);
        if (abort && as == 3) begin
          dq.delete();
          #2 reset = 1'b0;
          #1 chk("async_reset", {25'd0, in_w, inst_w, busy}, 32'd0);
          break;
        end
        if (pulse && as == 2) start = 1'b1;
        if (as == as_at && ar > 0) begin
          ar--;
        end else begin
          a_valid = 1'b1;
          a_data  = acts[as];
          if (a_ready) begin
            sq.push_back({2'b10, acts[as]});
            as++;
          end
        end
      end
    end
    if (guard >= 300) chk("feed_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_done(input bit hold_start, input int next_na);
    int g = 0;
    bit seen = 1'b0;
    while (g < 200 && !seen) begin
      @(negedge clk);
      g++;
      w_valid = 1'b0;
      a_valid = 1'b0;
      start   = hold_start;
      num_act = LBW'(next_na);
      seen    = done;
    end
    if (!seen) chk("done_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; num_act = '0;
    w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0;
    repeat (3) begin
      @(negedge clk);
      start   = 1'($urandom);
      num_act = LBW'($urandom);
      w_valid = 1'($urandom);
      w_data  = BW'($urandom);
      a_valid = 1'($urandom);
      a_data  = BW'($urandom);
    end
    @(negedge clk);
    start = 1'b0; w_valid = 1'b0; a_valid = 1'b0;
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Nominal job
    begin_job(6, 0);
    feed(6, -1, 0, -1, 0, 1'b0, 1'b0);
    wait_done(1'b0, 0);

    // Stalls: 2 in LOAD after 3 weights, 3 in EXEC after 2 activations
    @(negedge clk);
    begin_job(6, 5);
    feed(6, 3, 2, 2, 3, 1'b0, 1'b0);
    wait_done(1'b0, 0);

    // Zero activations
    @(negedge clk);
    no_a_ready = 1'b1;
    begin_job(0, 0);
    feed(0, -1, 0, -1, 0, 1'b0, 1'b0);
    wait_done(1'b0, 0);
    @(negedge clk);
    no_a_ready = 1'b0;

    // Start pulsed in EXEC, then start held through done for a chained job
    begin_job(6, 0);
    feed(6, -1, 0, -1, 0, 1'b1, 1'b0);
    expect_restart = 1'b1;
    wait_done(1'b1, 6);
    begin_job(6, 0);
    feed(6, -1, 0, -1, 0, 1'b0, 1'b0);
    expect_restart = 1'b0;
    wait_done(1'b0, 0);

    // Mid-job reset after 3 activations, then a fresh nominal job
    @(negedge clk);
    begin_job(6, 0);
    feed(6, -1, 0, -1, 0, 1'b0, 1'b1);
    start = 1'b0; w_valid = 1'b0; a_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    begin_job(6, 0);
    feed(6, -1, 0, -1, 0, 1'b0, 1'b0);
    wait_done(1'b0, 0);

    repeat (4) @(negedge clk);
    chk("xfer_queue_empty", sq.size(), 32'd0);
    chk("done_queue_empty", dq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_mac_row_ctrl
`default_nettype wire
